// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router synchroniser: port addresses, timeout length and
// the one-hot decode of a latched destination address.
package router_pkg;

  localparam logic [1:0] ADDR_P0   = 2'b00;
  localparam logic [1:0] ADDR_P1   = 2'b01;
  localparam logic [1:0] ADDR_P2   = 2'b10;
  localparam logic [1:0] ADDR_NONE = 2'b11;

  localparam int unsigned TIMEOUT = 30;
  localparam int unsigned CNT_W   = 5;

  typedef logic [CNT_W-1:0] cnt_t;

  // Invalid address selects no FIFO.
  function automatic logic [2:0] addr_onehot(input logic [1:0] addr);
    logic [2:0] oh;
    oh = 3'b000;
    case (addr)
      ADDR_P0: oh = 3'b001;
      ADDR_P1: oh = 3'b010;
      ADDR_P2: oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/router_sync_ctrl_if.sv
// Signal bundle between the router FSM / output FIFOs / port readers and the synchroniser.
// The synchroniser takes the slave view; the surrounding logic takes the master view.
interface router_sync_ctrl_if;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_en_reg;
  logic       re_0, re_1, re_2;
  logic       empty_0, empty_1, empty_2;
  logic       full_0, full_1, full_2;
  logic       valid_0, valid_1, valid_2;
  logic [2:0] write_en;
  logic       fifo_full;
  logic       sft_rst_0, sft_rst_1, sft_rst_2;

  modport master (
    output detect_add, data_in, write_en_reg,
    output re_0, re_1, re_2, empty_0, empty_1, empty_2, full_0, full_1, full_2,
    input  valid_0, valid_1, valid_2, write_en, fifo_full,
    input  sft_rst_0, sft_rst_1, sft_rst_2
  );

  modport slave (
    input  detect_add, data_in, write_en_reg,
    input  re_0, re_1, re_2, empty_0, empty_1, empty_2, full_0, full_1, full_2,
    output valid_0, valid_1, valid_2, write_en, fifo_full,
    output sft_rst_0, sft_rst_1, sft_rst_2
  );
endinterface

// File: rtl/router_sync_timer.sv
// Per-port unread-data watchdog: after TIMEOUT consecutive edges with data valid and not
// read, emits a one-cycle soft-reset pulse and restarts counting.
module router_sync_timer
  import router_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic valid,
  input  logic re,
  output logic sft_rst
);

  localparam cnt_t CntLast = cnt_t'(TIMEOUT - 1);

  cnt_t cnt_q, cnt_d;
  logic pulse_q, pulse_d;

  // Any read or empty FIFO restarts the count and kills the pulse.
  always_comb begin
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (valid && !re) begin
      if (cnt_q == CntLast) begin
        pulse_d = 1'b1;
      end else begin
        cnt_d = cnt_q + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign sft_rst = pulse_q;

endmodule

// File: rtl/router_sync_ctrl.sv
// Router synchroniser: latches the header address, steers the FSM write strobe to the
// addressed FIFO, returns its full flag, and watches each port for stale data.
module router_sync_ctrl
  import router_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  router_sync_ctrl_if.slave  bus
);

  logic [1:0] addr_q, addr_d;
  logic [2:0] write_en;
  logic       fifo_full;
  logic       valid_0, valid_1, valid_2;
  logic       sft_rst_0, sft_rst_1, sft_rst_2;

  always_comb begin
    addr_d = addr_q;
    if (bus.detect_add) begin
      addr_d = bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= ADDR_P0;
    end else begin
      addr_q <= addr_d;
    end
  end

  // Muxes use the registered address, so a same-cycle header load steers from the next cycle.
  always_comb begin
    write_en  = bus.write_en_reg ? addr_onehot(addr_q) : 3'b000;
    fifo_full = 1'b0;
    case (addr_q)
      ADDR_P0: fifo_full = bus.full_0;
      ADDR_P1: fifo_full = bus.full_1;
      ADDR_P2: fifo_full = bus.full_2;
      default: fifo_full = 1'b0;
    endcase
  end

  assign valid_0 = ~bus.empty_0;
  assign valid_1 = ~bus.empty_1;
  assign valid_2 = ~bus.empty_2;

  router_sync_timer u_timer_0 (
    .clk     (clk),
    .rst     (rst),
    .valid   (valid_0),
    .re      (bus.re_0),
    .sft_rst (sft_rst_0)
  );

  router_sync_timer u_timer_1 (
    .clk     (clk),
    .rst     (rst),
    .valid   (valid_1),
    .re      (bus.re_1),
    .sft_rst (sft_rst_1)
  );

  router_sync_timer u_timer_2 (
    .clk     (clk),
    .rst     (rst),
    .valid   (valid_2),
    .re      (bus.re_2),
    .sft_rst (sft_rst_2)
  );

  assign bus.write_en  = write_en;
  assign bus.fifo_full = fifo_full;
  assign bus.valid_0   = valid_0;
  assign bus.valid_1   = valid_1;
  assign bus.valid_2   = valid_2;
  assign bus.sft_rst_0 = sft_rst_0;
  assign bus.sft_rst_1 = sft_rst_1;
  assign bus.sft_rst_2 = sft_rst_2;

endmodule

// File: tb/tb_router_sync_ctrl.sv
// Self-checking bench for router_sync_ctrl: address steering, valid flags and the
// per-port stale-data soft-reset pulses, with expectations queued ahead of each sample.
module tb_router_sync_ctrl;
  import router_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] sb[$];
  logic [3:0] exp_v;
  int   streak[3];

  router_sync_ctrl_if bus ();

  router_sync_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ports();
    bus.empty_0 = 1'b1; bus.empty_1 = 1'b1; bus.empty_2 = 1'b1;
    bus.re_0 = 1'b1; bus.re_1 = 1'b1; bus.re_2 = 1'b1;
  endtask

  task automatic latch_addr(input logic [1:0] a);
    bus.detect_add = 1'b1;
    bus.data_in    = a;
    step();
    bus.detect_add = 1'b0;
  endtask

  // Unread-streak model for the edge about to happen; pulse on every 30th consecutive edge.
  function automatic logic [3:0] predict();
    logic [2:0] v;
    logic [2:0] r;
    logic [2:0] p;
    v = ~{bus.empty_2, bus.empty_1, bus.empty_0};
    r = {bus.re_2, bus.re_1, bus.re_0};
    p = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (v[i] && !r[i]) streak[i] = streak[i] + 1;
      else streak[i] = 0;
      p[i] = (streak[i] != 0) && (streak[i] % 30 == 0);
    end
    return {1'b0, p};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    bus.detect_add = 1'b0; bus.data_in = 2'b00; bus.write_en_reg = 1'b0;
    bus.re_0 = 1'b0; bus.re_1 = 1'b0; bus.re_2 = 1'b0;
    bus.empty_0 = 1'b0; bus.empty_1 = 1'b0; bus.empty_2 = 1'b0;
    bus.full_0 = 1'b0; bus.full_1 = 1'b0; bus.full_2 = 1'b0;
    #3;
    sb.push_back(4'b0000);
    exp_v = sb.pop_front(); checks++;
    if ({bus.sft_rst_2, bus.sft_rst_1, bus.sft_rst_0} !== exp_v[2:0]) begin
      errors++;
      $display("FAIL reset_sft: got %b expected %b",
               {bus.sft_rst_2, bus.sft_rst_1, bus.sft_rst_0}, exp_v[2:0]);
    end
    sb.push_back(4'b0111);
    exp_v = sb.pop_front(); checks++;
    if ({bus.valid_2, bus.valid_1, bus.valid_0} !== exp_v[2:0]) begin
      errors++;
      $display("FAIL reset_valid: got %b expected %b",
               {bus.valid_2, bus.valid_1, bus.valid_0}, exp_v[2:0]);
    end
    sb.push_back(4'b0000);
    exp_v = sb.pop_front(); checks++;
    if ({bus.fifo_full, bus.write_en} !== exp_v) begin
      errors++;
      $display("FAIL reset_write_en: got %b expected %b", {bus.fifo_full, bus.write_en}, exp_v);
    end
    // Clock edges while held in reset must not advance the timers.
    step();
    step();
    sb.push_back(4'b0000);
    exp_v = sb.pop_front(); checks++;
    if ({bus.sft_rst_2, bus.sft_rst_1, bus.sft_rst_0} !== exp_v[2:0]) begin
      errors++;
      $display("FAIL reset_hold_sft: got %b expected %b",
               {bus.sft_rst_2, bus.sft_rst_1, bus.sft_rst_0}, exp_v[2:0]);
    end
    idle_ports();
    bus.write_en_reg = 1'b1;
    rst = 1'b1;
    streak = '{0, 0, 0};
    #1;
    sb.push_back(4'b0001);
    exp_v = sb.pop_front(); checks++;
    if ({bus.fifo_full, bus.write_en} !== exp_v) begin
      errors++;
      $display("FAIL reset_release_we: got %b expected %b", {bus.fifo_full, bus.write_en}, exp_v);
    end
  endtask

  task automatic test_steering();
    logic [1:0] addrs[4];
    logic [2:0] fulls[4];
    logic [3:0] exps[4];
    addrs = '{ADDR_P1, ADDR_P1, ADDR_P2, ADDR_NONE};
    fulls = '{3'b010, 3'b101, 3'b100, 3'b111};
    exps  = '{4'b1010, 4'b0010, 4'b1100, 4'b0000};
    idle_ports();
    for (int i = 0; i < 4; i++) begin
      bus.write_en_reg = 1'b0;
      latch_addr(addrs[i]);
      bus.write_en_reg = 1'b1;
      {bus.full_2, bus.full_1, bus.full_0} = fulls[i];
      sb.push_back(exps[i]);
      #1;
      exp_v = sb.pop_front(); checks++;
      if ({bus.fifo_full, bus.write_en} !== exp_v) begin
        errors++;
        $display("FAIL steer_%0d: got %b expected %b", i, {bus.fifo_full, bus.write_en}, exp_v);
      end
    end
    // No write request: no strobe, but full still reflects the addressed FIFO.
    latch_addr(ADDR_P0);
    bus.write_en_reg = 1'b0;
    {bus.full_2, bus.full_1, bus.full_0} = 3'b001;
    sb.push_back(4'b1000);
    #1;
    exp_v = sb.pop_front(); checks++;
    if ({bus.fifo_full, bus.write_en} !== exp_v) begin
      errors++;
      $display("FAIL steer_no_req: got %b expected %b", {bus.fifo_full, bus.write_en}, exp_v);
    end
  endtask

  task automatic test_hold();
    idle_ports();
    latch_addr(ADDR_P0);
    bus.data_in = ADDR_P2;
    bus.write_en_reg = 1'b1;
    {bus.full_2, bus.full_1, bus.full_0} = 3'b100;
    sb.push_back(4'b0001);
    step(); step(); step();
    exp_v = sb.pop_front(); checks++;
    if ({bus.fifo_full, bus.write_en} !== exp_v) begin
      errors++;
      $display("FAIL addr_hold: got %b expected %b", {bus.fifo_full, bus.write_en}, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq[3];
    logic [3:0] exps[3];
    seq  = '{ADDR_P1, ADDR_P2, ADDR_P0};
    exps = '{4'b0010, 4'b0100, 4'b0001};
    idle_ports();
    {bus.full_2, bus.full_1, bus.full_0} = 3'b000;
    latch_addr(ADDR_P0);
    bus.write_en_reg = 1'b1;
    bus.detect_add = 1'b1;
    bus.data_in = seq[0];
    sb.push_back(4'b0001);
    #1;
    exp_v = sb.pop_front(); checks++;
    if ({bus.fifo_full, bus.write_en} !== exp_v) begin
      errors++;
      $display("FAIL b2b_before_edge: got %b expected %b", {bus.fifo_full, bus.write_en}, exp_v);
    end
    for (int i = 0; i < 3; i++) begin
      bus.data_in = seq[i];
      sb.push_back(exps[i]);
      step();
      exp_v = sb.pop_front(); checks++;
      if ({bus.fifo_full, bus.write_en} !== exp_v) begin
        errors++;
        $display("FAIL b2b_%0d: got %b expected %b", i, {bus.fifo_full, bus.write_en}, exp_v);
      end
    end
    bus.detect_add = 1'b0;
  endtask

  task automatic test_valid();
    bus.re_0 = 1'b1; bus.re_1 = 1'b1; bus.re_2 = 1'b1;
    for (int e = 0; e < 8; e++) begin
      {bus.empty_2, bus.empty_1, bus.empty_0} = 3'(e);
      sb.push_back({1'b0, ~3'(e)});
      #1;
      exp_v = sb.pop_front(); checks++;
      if ({bus.valid_2, bus.valid_1, bus.valid_0} !== exp_v[2:0]) begin
        errors++;
        $display("FAIL valid_%0d: got %b expected %b", e,
                 {bus.valid_2, bus.valid_1, bus.valid_0}, exp_v[2:0]);
      end
    end
    idle_ports();
  endtask

  task automatic test_timeout();
    idle_ports();
    step();
    streak = '{0, 0, 0};
    bus.empty_0 = 1'b0;
    bus.re_0 = 1'b0;
    for (int n = 0; n < 105; n++) begin
      if (n == 65) bus.re_0 = 1'b1;
      sb.push_back(predict());
      step();
      exp_v = sb.pop_front(); checks++;
      if ({bus.sft_rst_2, bus.sft_rst_1, bus.sft_rst_0} !== exp_v[2:0]) begin
        errors++;
        $display("FAIL timeout_edge%0d: got %b expected %b", n + 1,
                 {bus.sft_rst_2, bus.sft_rst_1, bus.sft_rst_0}, exp_v[2:0]);
      end
    end
  endtask

  task automatic test_counter_clear();
    idle_ports();
    step();
    streak = '{0, 0, 0};
    bus.empty_0 = 1'b0;
    for (int n = 0; n < 56; n++) begin
      bus.re_0 = (n == 20);
      sb.push_back(predict());
      step();
      exp_v = sb.pop_front(); checks++;
      if ({bus.sft_rst_2, bus.sft_rst_1, bus.sft_rst_0} !== exp_v[2:0]) begin
        errors++;
        $display("FAIL clear_edge%0d: got %b expected %b", n + 1,
                 {bus.sft_rst_2, bus.sft_rst_1, bus.sft_rst_0}, exp_v[2:0]);
      end
    end
  endtask

  task automatic test_multi_port();
    idle_ports();
    step();
    streak = '{0, 0, 0};
    bus.empty_0 = 1'b0; bus.empty_1 = 1'b0; bus.empty_2 = 1'b0;
    bus.re_0 = 1'b0; bus.re_1 = 1'b0; bus.re_2 = 1'b0;
    for (int n = 0; n < 35; n++) begin
      // Port 1 is read once mid-way so it lags the other two.
      bus.re_1 = (n == 4);
      sb.push_back(predict());
      step();
      exp_v = sb.pop_front(); checks++;
      if ({bus.sft_rst_2, bus.sft_rst_1, bus.sft_rst_0} !== exp_v[2:0]) begin
        errors++;
        $display("FAIL multi_edge%0d: got %b expected %b", n + 1,
                 {bus.sft_rst_2, bus.sft_rst_1, bus.sft_rst_0}, exp_v[2:0]);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    idle_ports();
    step();
    streak = '{0, 0, 0};
    bus.empty_0 = 1'b0;
    bus.re_0 = 1'b0;
    for (int n = 0; n < 55; n++) begin
      if (n == 25) begin
        rst = 1'b0;
        step();
        rst = 1'b1;
        streak = '{0, 0, 0};
      end
      sb.push_back(predict());
      step();
      exp_v = sb.pop_front(); checks++;
      if ({bus.sft_rst_2, bus.sft_rst_1, bus.sft_rst_0} !== exp_v[2:0]) begin
        errors++;
        $display("FAIL rst_mid_edge%0d: got %b expected %b", n + 1,
                 {bus.sft_rst_2, bus.sft_rst_1, bus.sft_rst_0}, exp_v[2:0]);
      end
    end
    // Last edge above produced a pulse; reset must kill it without waiting for a clock.
    rst = 1'b0;
    sb.push_back(4'b0000);
    #1;
    exp_v = sb.pop_front(); checks++;
    if ({bus.sft_rst_2, bus.sft_rst_1, bus.sft_rst_0} !== exp_v[2:0]) begin
      errors++;
      $display("FAIL rst_abort_pulse: got %b expected %b",
               {bus.sft_rst_2, bus.sft_rst_1, bus.sft_rst_0}, exp_v[2:0]);
    end
    step();
    rst = 1'b1;
    streak = '{0, 0, 0};
    idle_ports();
    step();
  endtask

  initial begin
    test_reset();
    test_steering();
    test_hold();
    test_back_to_back();
    test_valid();
    test_timeout();
    test_counter_clear();
    test_multi_port();
    test_reset_mid_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
